// File: rtl/mile_seven_seg_driver_pkg.sv
// Shared types and constants for the mileage seven-segment display slice.
package mile_seven_seg_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } convState_t;

    localparam int unsigned CONV_BITS   = 14;
    localparam int unsigned BCD_BITS    = 16;
    localparam int unsigned DIGIT_IDX_W = 2;

    // Active-low segments, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] segEncode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/mile_seven_seg_driver_if.sv
// Bus between the distance stage / display pins and the display driver.
interface mile_seven_seg_driver_if;

    logic [mile_seven_seg_driver_pkg::CONV_BITS-1:0] mileCounter;
    logic [3:0]                                       anodeSelect;
    logic [6:0]                                       sevenSeg;
    logic                                             decimalPoint;
    logic                                             convBusy;

    modport master (
        output mileCounter,
        input  anodeSelect,
        input  sevenSeg,
        input  decimalPoint,
        input  convBusy
    );

    modport slave (
        input  mileCounter,
        output anodeSelect,
        output sevenSeg,
        output decimalPoint,
        output convBusy
    );

endinterface

// File: rtl/mile_seven_seg_driver_bin2bcd_seq.sv
// Sequential double-dabble: one adjust+shift per cycle, 14 cycles per conversion.
module bin2bcd_seq
    import mile_seven_seg_driver_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [CONV_BITS-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_BITS-1:0]  bcd
);

    localparam logic [3:0] LAST_SHIFT = 4'(CONV_BITS - 1);

    convState_t           state;
    convState_t           stateNext;
    logic [CONV_BITS-1:0] shiftReg;
    logic [BCD_BITS-1:0]  bcdAcc;
    logic [BCD_BITS-1:0]  bcdAdj;
    logic [3:0]           shiftCnt;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: start only honoured in IDLE, fixed 14 shifts, one commit cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   if (shiftCnt == LAST_SHIFT) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Add-3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        bcdAdj = bcdAcc;
        for (int unsigned i = 0; i < BCD_BITS / 4; i++) begin
            if (bcdAcc[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath: load on start, shift the {bcd, binary} pair left in SHIFT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shiftReg <= '0;
            bcdAcc   <= '0;
            shiftCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= bin;
                        bcdAcc   <= '0;
                        shiftCnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcdAcc, shiftReg} <= {bcdAdj[BCD_BITS-2:0], shiftReg, 1'b0};
                    shiftCnt           <= shiftCnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        bcd  = bcdAcc;
    end

endmodule

// File: rtl/mile_seven_seg_driver.sv
// Four-digit multiplexed mileage display: clamp, BCD conversion, refresh, blanking.
module mile_seven_seg_driver
    import mile_seven_seg_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned MAX_TENTHS  = 9999
) (
    input  logic                    CLK,
    input  logic                    RESET,
    mile_seven_seg_driver_if.slave  bus
);

    localparam int unsigned          CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CONV_BITS-1:0] MAX_VAL  = CONV_BITS'(MAX_TENTHS);

    logic [CONV_BITS-1:0]   clamped;
    logic [CONV_BITS-1:0]   committedBin;
    logic [CONV_BITS-1:0]   pendingBin;
    logic [BCD_BITS-1:0]    dispBcd;
    logic [BCD_BITS-1:0]    bcdView;
    logic [BCD_BITS-1:0]    convBcd;
    logic                   convBusyInt;
    logic                   convDone;
    logic                   start;
    logic [CNT_W-1:0]       refreshCnt;
    logic                   refreshWrap;
    logic [DIGIT_IDX_W-1:0] digitIdx;
    logic [DIGIT_IDX_W-1:0] digitIdxNext;
    logic [3:0]             digitVal;
    logic                   digitBlank;
    logic [6:0]             segNext;
    logic [3:0]             anodeNext;
    logic                   dpNext;

    // Clamp the input and request a conversion when it differs from what is shown.
    always_comb begin
        clamped = (bus.mileCounter > MAX_VAL) ? MAX_VAL : bus.mileCounter;
        start   = !convBusyInt && (clamped != committedBin);
    end

    bin2bcd_seq u_bin2bcd (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start),
        .bin   (clamped),
        .busy  (convBusyInt),
        .done  (convDone),
        .bcd   (convBcd)
    );

    assign bus.convBusy = convBusyInt;

    // Capture the value being converted; commit digits and value together on done.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pendingBin   <= '0;
            committedBin <= '0;
            dispBcd      <= '0;
        end else begin
            if (start) begin
                pendingBin <= clamped;
            end
            if (convDone) begin
                dispBcd      <= convBcd;
                committedBin <= pendingBin;
            end
        end
    end

    // Refresh divider and digit index, free-running independent of conversions.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            refreshCnt <= '0;
            digitIdx   <= '0;
        end else begin
            refreshCnt <= refreshWrap ? '0 : refreshCnt + 1'b1;
            digitIdx   <= digitIdxNext;
        end
    end

    // Select, blank and encode the digit the output registers will show next.
    // The commit cycle feeds the fresh BCD straight through so the new value
    // appears on the same edge that the display registers take it.
    always_comb begin
        refreshWrap  = (refreshCnt == CNT_LAST);
        digitIdxNext = refreshWrap ? digitIdx + 2'd1 : digitIdx;
        bcdView      = convDone ? convBcd : dispBcd;
        digitVal     = bcdView[{digitIdxNext, 2'b00} +: 4];
        case (digitIdxNext)
            2'd3:    digitBlank = (bcdView[15:12] == 4'd0);
            2'd2:    digitBlank = (bcdView[15:8] == 8'd0);
            default: digitBlank = 1'b0;
        endcase
        segNext   = digitBlank ? SEG_BLANK : segEncode(digitVal);
        anodeNext = ~(4'b0001 << digitIdxNext);
        dpNext    = (digitIdxNext != 2'd1);
    end

    // Registered display outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.anodeSelect  <= '1;
            bus.sevenSeg     <= SEG_BLANK;
            bus.decimalPoint <= 1'b1;
        end else begin
            bus.anodeSelect  <= anodeNext;
            bus.sevenSeg     <= segNext;
            bus.decimalPoint <= dpNext;
        end
    end

endmodule

// File: doc/mile_seven_seg_driver.md
MILE_SEVEN_SEG_DRIVER -- requirements
Module: mile_seven_seg_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the CLK cycles each digit is lit (1 kHz per digit at 100 MHz).
REQ-002 The block SHALL have parameter MAX_TENTHS, default 9999, giving the largest displayable value in tenths of a mile.
REQ-003 Port CLK SHALL be an input, 1 bit, and the single clock for all logic.
REQ-004 Port RESET SHALL be an input, 1 bit, synchronous active-high reset.
REQ-005 Port mileCounter SHALL be an input, 14 bits, the distance in tenths of a mile (unsigned binary) from the distance stage.
REQ-006 Port anodeSelect SHALL be an output, 4 bits, active-low digit enables; bit0 is the rightmost digit (tenths).
REQ-007 Port sevenSeg SHALL be an output, 7 bits, active-low segments; bit0=a through bit6=g.
REQ-008 Port decimalPoint SHALL be an output, 1 bit, the active-low decimal point.
REQ-009 Port convBusy SHALL be an output, 1 bit, high while a binary-to-BCD conversion is in progress.

Function
REQ-010 The input SHALL be clamped: values above MAX_TENTHS are converted as MAX_TENTHS (9999 shows "999.9").
REQ-011 The converter SHALL be an FSM with states IDLE, SHIFT and DONE, using sequential double-dabble (add-3-if-≥5 per BCD nibble, then shift left 1).
REQ-012 IDLE: when the clamped input differs from the last committed binary value, the FSM SHALL load the input into the shift register, clear the BCD accumulator, set the shift count to 0 and go to SHIFT.
REQ-013 SHIFT: the FSM SHALL perform one adjust+shift per cycle for exactly 14 cycles, then go to DONE.
REQ-014 DONE: the FSM SHALL write the four BCD digits and the committed binary value into the display registers in one cycle (atomic update), then return to IDLE.
REQ-015 Latency SHALL be 16 cycles from the sampling edge to visible digits (1 load, 14 shift, 1 commit).
REQ-016 convBusy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-017 Input changes during SHIFT or DONE SHALL be ignored by the running conversion and sampled on the next IDLE cycle; no intermediate value is displayed.
REQ-018 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On wrap, the digit index SHALL advance 0→1→2→3→0.
REQ-019 Exactly one anodeSelect bit SHALL be low at any time outside reset, namely the bit of the current digit index.
REQ-020 sevenSeg SHALL show the hex-to-7-seg encoding of the indexed BCD digit, with outputs registered and aligned to anodeSelect in the same cycle.
REQ-021 Leading-zero blanking: digit3 SHALL be blank (all segments 1) when it is 0. Digit2 SHALL be blank when digits 3 and 2 are both 0. Digits 1 and 0 SHALL never be blanked, so 0 shows "0.0".
REQ-022 decimalPoint SHALL be 0 (lit) only while digit index = 1, and 1 otherwise.
REQ-023 Display refresh SHALL continue without interruption during conversions.

Reset
REQ-024 While RESET=1 at a clock edge: anodeSelect=4'b1111, sevenSeg=7'b1111111, decimalPoint=1, convBusy=0, FSM=IDLE, BCD digits=0, committed value=0, refresh counter=0, digit index=0.
REQ-025 RESET asserted mid-conversion SHALL abort it with no commit.
REQ-026 On the first edge after RESET deasserts, anodeSelect SHALL be 4'b1110, showing "0" on digit0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the CONV_BITS=14 constant, the 10 segment encodings plus the BLANK pattern, and the digit-index width.
REQ-028 Double-dabble logic SHALL live in sub-module bin2bcd_seq (ports CLK, RESET, start, bin[13:0], busy, done, bcd[15:0]). The top SHALL hold the clamp, refresh, mux and blanking logic.

Verification
REQ-029 Reset, then mileCounter=0 for 4·REFRESH_DIV cycles → digits 3 and 2 blank, digit1 "0" with DP lit, digit0 "0".
REQ-030 mileCounter 0→5 at edge k → convBusy high from k+1 through k+15; display "0.5" valid after k+15 and unchanged before.
REQ-031 mileCounter=10000 → display "999.9"; mileCounter=16383 → display "999.9".
REQ-032 mileCounter=1235, changed to 40 at 5 cycles into SHIFT → "123.5" commits first, then "4.0" within a further 16 cycles; no other value ever appears.
REQ-033 RESET pulsed 7 cycles into a conversion of 9999 → all outputs at reset values, display "0.0" afterwards, with no commit of 9999.
REQ-034 REFRESH_DIV=4, steady input 1234 → anodeSelect cycles 1110,1101,1011,0111 every 4 cycles, with segments matching 4,3,2,1 and DP on 1101 only.
